// File: rtl/breakout_ball_ctrl_if.sv
// Playfield-facing bundle between breakout_ball_ctrl (master) and breakout_playfield (slave).
interface breakout_ball_ctrl_if;
  logic [9:0] CounterX;
  logic [8:0] CounterY;
  logic       DrawBorder;
  logic       DrawPaddle;
  logic       DrawBrick;
  logic       BrickHit_acq;
  logic [9:0] ballX;
  logic [8:0] bally;
  logic       BrickHit_now;
  logic       RestorBrickWall;

  modport master (
    input  CounterX, CounterY, DrawBorder, DrawPaddle, DrawBrick, BrickHit_acq,
    output ballX, bally, BrickHit_now, RestorBrickWall
  );

  modport slave (
    output CounterX, CounterY, DrawBorder, DrawPaddle, DrawBrick, BrickHit_acq,
    input  ballX, bally, BrickHit_now, RestorBrickWall
  );
endinterface

// File: rtl/breakout_ball_ctrl.sv
// Breakout ball motion, collision and serve/play/lose/restore sequencing; one move per frame.
// Optional feature macro: BALL_SPEEDUP_EN (ball step doubles after SPEEDUP_HITS bricks per level).
module breakout_ball_ctrl #(
  parameter int unsigned LIVES   = 3,
  parameter int unsigned BRICKS  = 133,
  parameter int unsigned SERVE_Y = 418,
  parameter int unsigned LOSE_Y  = 440
`ifdef BALL_SPEEDUP_EN
  , parameter int unsigned SPEEDUP_HITS = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_tick,
  input  logic [9:0]           PaddleX,
  input  logic                 launch,
  breakout_ball_ctrl_if.master pf,
  output logic [7:0]           score,
  output logic [1:0]           lives,
  output logic                 game_over
);

  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;
  localparam int unsigned CW = 8;

  typedef enum logic [2:0] {
    S_RESTORE,
    S_SERVE,
    S_PLAY,
    S_LOST,
    S_GAME_OVER
  } state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   ball_x_q, ball_x_d;
  logic [YW-1:0]   ball_y_q, ball_y_d;
  logic            dir_x_neg_q, dir_x_neg_d;
  logic            dir_y_neg_q, dir_y_neg_d;
  logic [CW-1:0]   score_q, score_d;
  logic [1:0]      lives_q, lives_d;
  logic [CW-1:0]   bricks_q, bricks_d;
  logic [3:0]      flags_q, flags_d;
  logic [3:0]      probe_q;
  logic            restore_q, restore_d;
  logic            game_over_q, game_over_d;
  logic [1:0]      step;

  logic [3:0]      probe_hit;
  logic            draw_any;
  logic [XW-1:0]   new_x;
  logic [YW-1:0]   new_y;
  logic            nx_neg, ny_neg;

  // Probe pixels around the ball: [0]=left, [1]=right, [2]=top, [3]=bottom
  always_comb begin
    probe_hit    = '0;
    probe_hit[0] = (pf.CounterX == ball_x_q - XW'(1))  && (pf.CounterY == ball_y_q + YW'(8));
    probe_hit[1] = (pf.CounterX == ball_x_q + XW'(16)) && (pf.CounterY == ball_y_q + YW'(8));
    probe_hit[2] = (pf.CounterX == ball_x_q + XW'(8))  && (pf.CounterY == ball_y_q - YW'(1));
    probe_hit[3] = (pf.CounterX == ball_x_q + XW'(8))  && (pf.CounterY == ball_y_q + YW'(16));
  end

  assign draw_any = pf.DrawBorder | pf.DrawPaddle | pf.DrawBrick;

`ifdef BALL_SPEEDUP_EN
  logic [CW-1:0] hits_q, hits_d;
  logic [1:0]    step_q, step_d;

  // Per-level hit count; cleared while the ball is parked so each serve restarts slow
  always_comb begin
    hits_d = hits_q;
    if (pf.BrickHit_acq && (hits_q < CW'(SPEEDUP_HITS))) hits_d = hits_q + CW'(1);
    step_d = (hits_d >= CW'(SPEEDUP_HITS)) ? 2'd2 : 2'd1;
    if ((state_q == S_RESTORE) || (state_q == S_SERVE)) begin
      hits_d = '0;
      step_d = 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q <= '0;
      step_q <= 2'd1;
    end else begin
      hits_q <= hits_d;
      step_q <= step_d;
    end
  end

  assign step = step_q;
`else
  assign step = 2'd1;
`endif

  // Bounce direction from this frame's flags, then move with the new direction
  always_comb begin
    nx_neg = dir_x_neg_q;
    ny_neg = dir_y_neg_q;
    if (flags_q[0] && !flags_q[1]) nx_neg = 1'b0;
    if (flags_q[1] && !flags_q[0]) nx_neg = 1'b1;
    if (flags_q[2] && !flags_q[3]) ny_neg = 1'b0;
    if (flags_q[3] && !flags_q[2]) ny_neg = 1'b1;
    new_x = nx_neg ? (ball_x_q - XW'(step)) : (ball_x_q + XW'(step));
    new_y = ny_neg ? (ball_y_q - YW'(step)) : (ball_y_q + YW'(step));
  end

  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dir_x_neg_d = dir_x_neg_q;
    dir_y_neg_d = dir_y_neg_q;
    score_d     = score_q;
    lives_d     = lives_q;
    bricks_d    = bricks_q;
    flags_d     = flags_q;

    if (state_q == S_PLAY) flags_d = flags_q | (probe_q & {4{draw_any}});

    if (pf.BrickHit_acq) begin
      if (score_q != 8'hFF) score_d = score_q + CW'(1);
      if (bricks_q != '0)   bricks_d = bricks_q - CW'(1);
    end

    if (frame_tick) begin
      flags_d = '0;
      unique case (state_q)
        S_RESTORE: begin
          state_d  = S_SERVE;
          ball_x_d = PaddleX + XW'(24);
          ball_y_d = YW'(SERVE_Y);
        end
        S_SERVE: begin
          ball_x_d = PaddleX + XW'(24);
          ball_y_d = YW'(SERVE_Y);
          if (launch) begin
            state_d     = S_PLAY;
            dir_x_neg_d = 1'b0;
            dir_y_neg_d = 1'b1;
          end
        end
        S_PLAY: begin
          dir_x_neg_d = nx_neg;
          dir_y_neg_d = ny_neg;
          ball_x_d    = new_x;
          ball_y_d    = new_y;
          // Level clear takes priority over a simultaneous loss
          if (bricks_d == '0) begin
            state_d  = S_RESTORE;
            bricks_d = CW'(BRICKS);
          end else if (new_y >= YW'(LOSE_Y)) begin
            state_d = S_LOST;
            if (lives_q != '0) lives_d = lives_q - 2'd1;
          end
        end
        S_LOST: begin
          if (lives_q == '0) begin
            state_d = S_GAME_OVER;
          end else begin
            state_d  = S_SERVE;
            ball_x_d = PaddleX + XW'(24);
            ball_y_d = YW'(SERVE_Y);
          end
        end
        S_GAME_OVER: begin
          if (launch) begin
            state_d  = S_RESTORE;
            score_d  = '0;
            lives_d  = 2'(LIVES);
            bricks_d = CW'(BRICKS);
          end
        end
        default: state_d = S_RESTORE;
      endcase
    end

    restore_d   = (state_d == S_RESTORE);
    game_over_d = (state_d == S_GAME_OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESTORE;
      ball_x_q    <= XW'(312);
      ball_y_q    <= YW'(SERVE_Y);
      dir_x_neg_q <= 1'b0;
      dir_y_neg_q <= 1'b1;
      score_q     <= '0;
      lives_q     <= 2'(LIVES);
      bricks_q    <= CW'(BRICKS);
      flags_q     <= '0;
      probe_q     <= '0;
      restore_q   <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dir_x_neg_q <= dir_x_neg_d;
      dir_y_neg_q <= dir_y_neg_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      bricks_q    <= bricks_d;
      flags_q     <= flags_d;
      probe_q     <= probe_hit;
      restore_q   <= restore_d;
      game_over_q <= game_over_d;
    end
  end

  assign pf.ballX           = ball_x_q;
  assign pf.bally           = ball_y_q;
  assign pf.BrickHit_now    = (state_q == S_PLAY) && (|probe_hit);
  assign pf.RestorBrickWall = restore_q;
  assign score              = score_q;
  assign lives              = lives_q;
  assign game_over          = game_over_q;

endmodule

// File: tb/tb_breakout_ball_ctrl.sv
// Directed bench for breakout_ball_ctrl: serve, bounce, scoring, level clear, losses, game over.
module tb_breakout_ball_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] PaddleX = 10'd200;
  logic       launch = 1'b0;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;

  int n_cmp = 0;
  int n_bad = 0;

  breakout_ball_ctrl_if pf ();

  breakout_ball_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .PaddleX    (PaddleX),
    .launch     (launch),
    .pf         (pf.master),
    .score      (score),
    .lives      (lives),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic l);
    @(negedge clk);
    frame_tick = 1'b1;
    launch     = l;
    @(negedge clk);
    frame_tick = 1'b0;
    launch     = 1'b0;
  endtask

  task automatic acq(input logic with_tick);
    @(negedge clk);
    pf.BrickHit_acq = 1'b1;
    frame_tick      = with_tick;
    @(negedge clk);
    pf.BrickHit_acq = 1'b0;
    frame_tick      = 1'b0;
  endtask

  // Put the scan on the top probe, then raise DrawBorder one cycle later
  task automatic hit_top(input logic [9:0] x, input logic [8:0] y);
    @(negedge clk);
    pf.CounterX = x;
    pf.CounterY = y;
    #1 check("brickhit_now_on_probe", pf.BrickHit_now, 1);
    @(negedge clk);
    pf.CounterX   = 10'd0;
    pf.CounterY   = 9'd0;
    pf.DrawBorder = 1'b1;
    #1 check("brickhit_now_off_probe", pf.BrickHit_now, 0);
    @(negedge clk);
    pf.DrawBorder = 1'b0;
  endtask

  // From SERVE with PaddleX=200: launch, bounce off top, fall until lost
  task automatic lose_ball(input int exp_lives);
    tick(1'b1);
    check("launch_x", pf.ballX, 224);
    check("launch_y", pf.bally, 418);
    hit_top(10'd232, 9'd417);
    tick(1'b0);
    check("fall_x", pf.ballX, 225);
    check("fall_y", pf.bally, 419);
    repeat (20) tick(1'b0);
    check("before_lost_y", pf.bally, 439);
    check("before_lost_lives", lives, 32'(exp_lives + 1));
    tick(1'b0);
    check("lost_y", pf.bally, 440);
    check("lost_lives", lives, 32'(exp_lives));
    check("lost_not_over", game_over, 0);
  endtask

  initial begin
    pf.CounterX     = 10'd0;
    pf.CounterY     = 9'd0;
    pf.DrawBorder   = 1'b0;
    pf.DrawPaddle   = 1'b0;
    pf.DrawBrick    = 1'b0;
    pf.BrickHit_acq = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_restore", pf.RestorBrickWall, 1);
    check("rst_x", pf.ballX, 312);
    check("rst_y", pf.bally, 418);
    check("rst_score", score, 0);
    check("rst_lives", lives, 3);
    check("rst_over", game_over, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("restore_hold", pf.RestorBrickWall, 1);

    // Restore frame then serve
    tick(1'b0);
    check("serve_restore_low", pf.RestorBrickWall, 0);
    tick(1'b0);
    check("serve_x", pf.ballX, 224);
    check("serve_y", pf.bally, 418);

    // Launch and three free moves up-right
    tick(1'b1);
    repeat (3) tick(1'b0);
    check("play_x", pf.ballX, 227);
    check("play_y", pf.bally, 415);

    // Top bounce
    hit_top(10'd235, 9'd414);
    tick(1'b0);
    check("bounce_x", pf.ballX, 228);
    check("bounce_y", pf.bally, 416);

    // Scoring and level clear
    acq(1'b0);
    check("score_1", score, 1);
    repeat (131) acq(1'b0);
    check("score_132", score, 132);
    tick(1'b0);
    check("still_play", pf.RestorBrickWall, 0);
    check("move_x", pf.ballX, 229);
    check("move_y", pf.bally, 417);
    acq(1'b1);
    check("clear_restore", pf.RestorBrickWall, 1);
    check("clear_score", score, 133);
    check("clear_lives", lives, 3);
    tick(1'b0);
    check("reserve_restore_low", pf.RestorBrickWall, 0);
    check("reserve_x", pf.ballX, 224);

    // Three losses to game over
    lose_ball(2);
    tick(1'b0);
    check("serve2_x", pf.ballX, 224);
    lose_ball(1);
    tick(1'b0);
    check("serve3_y", pf.bally, 418);
    lose_ball(0);
    tick(1'b0);
    check("game_over", game_over, 1);
    check("over_score", score, 133);
    tick(1'b0);
    check("over_hold", game_over, 1);
    tick(1'b1);
    check("restart_restore", pf.RestorBrickWall, 1);
    check("restart_score", score, 0);
    check("restart_lives", lives, 3);
    check("restart_over", game_over, 0);

`ifdef BALL_SPEEDUP_EN
    tick(1'b0);
    tick(1'b1);
    repeat (16) acq(1'b0);
    tick(1'b0);
    check("fast_x", pf.ballX, 226);
    check("fast_y", pf.bally, 416);
    hit_top(10'd234, 9'd415);
    begin
      int guard = 0;
      while (lives == 2'd3 && guard < 40) begin
        tick(1'b0);
        guard++;
      end
      check("fast_lost_lives", lives, 2);
    end
    tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    check("slow_x", pf.ballX, 225);
    check("slow_y", pf.bally, 417);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
